// File: rtl/sqrt_pkg.sv
// Shared constants, flag positions and FSM state type for the FP16 sqrt scheduler.
package sqrt_pkg;

  localparam int unsigned FP_W   = 16;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [FP_W-1:0] QNAN = 16'hFE00;
  localparam logic [FP_W-1:0] PINF = 16'h7C00;
  localparam logic [FP_W-1:0] NINF = 16'hFC00;

  localparam int unsigned FLAG_NAN  = 2;
  localparam int unsigned FLAG_PINF = 1;
  localparam int unsigned FLAG_NINF = 0;

  // Flags reported with a timed-out response: quiet NaN only.
  localparam logic [FLAG_W-1:0] FLAGS_TIMEOUT = FLAG_W'(1) << FLAG_NAN;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

endpackage

// File: rtl/sqrt_sched_if.sv
// Requester, datapath and response signals of the sqrt scheduler.
interface sqrt_sched_if
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) ();

  logic [N_REQ-1:0]      req_valid;
  logic [FP_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;

  logic                  core_enable;
  logic                  core_start;
  logic [FP_W-1:0]       core_operand;
  logic                  core_p_valid;
  logic [FP_W-1:0]       core_result;
  logic [FLAG_W-1:0]     core_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [FP_W-1:0]       rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [FLAG_W-1:0]     rsp_flags;
  logic                  rsp_timeout;
  logic                  busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, core_p_valid, core_result, core_flags, rsp_ready,
    output req_ready, core_enable, core_start, core_operand,
           rsp_valid, rsp_data, rsp_id, rsp_flags, rsp_timeout, busy
  );

  // Requesters plus datapath side.
  modport master (
    output req_valid, req_data, core_p_valid, core_result, core_flags, rsp_ready,
    input  req_ready, core_enable, core_start, core_operand,
           rsp_valid, rsp_data, rsp_id, rsp_flags, rsp_timeout, busy
  );

endinterface

// File: rtl/sqrt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request after 'last', wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [ID_W-1:0] pos;

  // Scan N positions starting one past the previous winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = ID_W'((32'(last) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Sequences one FP16 sqrt operation at a time across N_REQ requesters.
module sqrt_sched
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned LAT_MAX = 16,
  parameter int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sqrt_sched_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FP_W-1:0]   op_q, op_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [FP_W-1:0]   rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              core_enable_q, core_enable_d;
  logic              core_start_q, core_start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  req_ready_c;

  logic [N_REQ-1:0]  grant_c;
  logic [ID_W-1:0]   grant_idx_c;
  logic              grant_found_c;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant_c),
    .idx   (grant_idx_c),
    .found (grant_found_c)
  );

  // Next-state, datapath capture and output decode.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    id_d          = id_q;
    rsp_data_d    = rsp_data_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready_c   = '0;
    unique case (state_q)
      IDLE: begin
        // Accept pulse is suppressed while reset is held so every output reads 0.
        if (grant_found_c && rst_n) begin
          req_ready_c = grant_c;
          op_d        = bus.req_data[32'(grant_idx_c) * FP_W +: FP_W];
          id_d        = grant_idx_c;
          last_d      = grant_idx_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_p_valid) begin
          rsp_data_d    = bus.core_result;
          rsp_flags_d   = bus.core_flags;
          rsp_timeout_d = 1'b0;
          state_d       = HOLD;
        end else if (cnt_q == CNT_W'(LAT_MAX - 1)) begin
          rsp_data_d    = QNAN;
          rsp_flags_d   = FLAGS_TIMEOUT;
          rsp_timeout_d = 1'b1;
          state_d       = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    core_enable_d = (state_d == ISSUE) || (state_d == WAIT);
    core_start_d  = (state_d == ISSUE);
    rsp_valid_d   = (state_d == HOLD);
    busy_d        = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(N_REQ - 1);
      cnt_q         <= '0;
      op_q          <= '0;
      id_q          <= '0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
      core_enable_q <= 1'b0;
      core_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      id_q          <= id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
      core_enable_q <= core_enable_d;
      core_start_q  <= core_start_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.core_enable  = core_enable_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_operand = op_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_flags    = rsp_flags_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched with a fixed-latency datapath model.
module tb_sqrt_sched;
  import sqrt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt_sched_if #(.N_REQ(2), .ID_W(1)) bus ();

  sqrt_sched #(.N_REQ(2), .LAT_MAX(16), .ID_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath model: p_valid L cycles after the cycle carrying core_start.
  int   cd = 0;
  int   lat = 3;
  logic auto_en = 1'b1;
  logic man_pv = 1'b0;
  always @(posedge clk) begin
    if (!bus.core_enable)    cd <= 0;
    else if (bus.core_start) cd <= lat;
    else if (cd > 0)         cd <= cd - 1;
  end
  assign bus.core_p_valid = (auto_en && cd == 1) || man_pv;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},   32'(bus.req_ready),    32'h0);
    chk({tag, "_core_enable"}, 32'(bus.core_enable),  32'h0);
    chk({tag, "_core_start"},  32'(bus.core_start),   32'h0);
    chk({tag, "_core_op"},     32'(bus.core_operand), 32'h0);
    chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),    32'h0);
    chk({tag, "_rsp_data"},    32'(bus.rsp_data),     32'h0);
    chk({tag, "_rsp_id"},      32'(bus.rsp_id),       32'h0);
    chk({tag, "_rsp_flags"},   32'(bus.rsp_flags),    32'h0);
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout),  32'h0);
    chk({tag, "_busy"},        32'(bus.busy),         32'h0);
  endtask

  initial begin
    int w;
    logic [1:0] exp_g;
    bus.req_valid   = 2'b00;
    bus.req_data    = {16'h3C00, 16'h4400};
    bus.rsp_ready   = 1'b0;
    bus.core_result = 16'h4000;
    bus.core_flags  = 3'b000;

    // Reset values
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single request, L=3
    bus.req_valid = 2'b01;
    #1;
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_start",   32'(bus.core_start),   32'h1);
    chk("t1_enable",  32'(bus.core_enable),  32'h1);
    chk("t1_operand", 32'(bus.core_operand), 32'h4400);
    chk("t1_noready", 32'(bus.req_ready),    32'h0);
    chk("t1_busy",    32'(bus.busy),         32'h1);
    tick();
    chk("t1_start_low", 32'(bus.core_start), 32'h0);
    tick();
    tick();
    chk("t1_early", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid",   32'(bus.rsp_valid),   32'h1);
    chk("t1_rsp_data",    32'(bus.rsp_data),    32'h4000);
    chk("t1_rsp_id",      32'(bus.rsp_id),      32'h0);
    chk("t1_rsp_flags",   32'(bus.rsp_flags),   32'h0);
    chk("t1_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t1_idle_busy",  32'(bus.busy),      32'h0);
    chk("t1_idle_valid", 32'(bus.rsp_valid), 32'h0);

    // 2: fairness after a fresh reset, both requesters always valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid   = 2'b11;
    bus.rsp_ready   = 1'b1;
    bus.core_result = 16'h3C00;
    for (int op = 0; op < 6; op++) begin
      exp_g = (op % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      w = 0;
      while (bus.req_ready == 2'b00 && w < 40) begin
        tick();
        w++;
      end
      chk("t2_grant", 32'(bus.req_ready), 32'(exp_g));
      tick();
      w = 0;
      while (!bus.rsp_valid && w < 40) begin
        chk("t2_onehot", 32'($onehot0(bus.req_ready)), 32'h1);
        tick();
        w++;
      end
      chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t2_rsp_id",    32'(bus.rsp_id),    32'(op % 2));
      chk("t2_rsp_data",  32'(bus.rsp_data),  32'h3C00);
      if (op == 5) bus.req_valid = 2'b00;
      tick();
    end
    bus.rsp_ready = 1'b0;

    // 3: timeout, then a late p_valid in HOLD and IDLE
    auto_en = 1'b0;
    bus.req_valid = 2'b01;
    #1;
    chk("t3_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    repeat (16) tick();
    chk("t3_before", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t3_rsp_valid",   32'(bus.rsp_valid),   32'h1);
    chk("t3_rsp_data",    32'(bus.rsp_data),    32'hFE00);
    chk("t3_rsp_flags",   32'(bus.rsp_flags),   32'h4);
    chk("t3_rsp_timeout", 32'(bus.rsp_timeout), 32'h1);
    chk("t3_rsp_id",      32'(bus.rsp_id),      32'h0);
    man_pv = 1'b1;
    bus.core_result = 16'h1234;
    bus.core_flags  = 3'b001;
    tick();
    chk("t3_late_hold_data",  32'(bus.rsp_data),    32'hFE00);
    chk("t3_late_hold_flags", 32'(bus.rsp_flags),   32'h4);
    chk("t3_late_hold_to",    32'(bus.rsp_timeout), 32'h1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t3_late_idle_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t3_late_idle_busy", 32'(bus.busy),     32'h0);
    chk("t3_late_idle_data", 32'(bus.rsp_data), 32'hFE00);
    man_pv = 1'b0;
    bus.core_flags = 3'b000;

    // 4: backpressure with requester 1 pending
    auto_en = 1'b1;
    lat = 2;
    bus.core_result = 16'h4200;
    bus.req_valid = 2'b01;
    #1;
    chk("t4_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b11;
    w = 0;
    while (!bus.rsp_valid && w < 40) begin
      tick();
      w++;
    end
    chk("t4_hold", 32'(bus.rsp_valid), 32'h1);
    repeat (10) begin
      chk("t4_stable_data",  32'(bus.rsp_data),  32'h4200);
      chk("t4_stable_id",    32'(bus.rsp_id),    32'h0);
      chk("t4_stable_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t4_no_ready",     32'(bus.req_ready), 32'h0);
      chk("t4_busy",         32'(bus.busy),      32'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t4_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    w = 0;
    while (!bus.rsp_valid && w < 40) begin
      tick();
      w++;
    end
    chk("t4_rsp1_id",   32'(bus.rsp_id),   32'h1);
    chk("t4_rsp1_data", 32'(bus.rsp_data), 32'h4200);
    tick();
    bus.rsp_ready = 1'b0;

    // 5: reset mid-WAIT, then requester 0 wins first
    auto_en = 1'b0;
    bus.req_valid = 2'b01;
    #1;
    chk("t5_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    chk("t5_busy", 32'(bus.busy), 32'h1);
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_first", 32'(bus.req_ready), 32'h1);

    // 6: p_valid in the last WAIT cycle wins over timeout
    tick();
    bus.req_valid = 2'b00;
    repeat (16) tick();
    chk("t6_before", 32'(bus.rsp_valid), 32'h0);
    man_pv = 1'b1;
    bus.core_result = 16'h7C00;
    bus.core_flags  = 3'b010;
    tick();
    man_pv = 1'b0;
    chk("t6_rsp_valid",   32'(bus.rsp_valid),   32'h1);
    chk("t6_rsp_data",    32'(bus.rsp_data),    32'h7C00);
    chk("t6_rsp_flags",   32'(bus.rsp_flags),   32'h2);
    chk("t6_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    chk("t6_rsp_id",      32'(bus.rsp_id),      32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t6_idle", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sqrt_sched.md
Name: sqrt_sched

Overview:
- Shares one FP16 square-root datapath (unpack, iterate, pack) between N_REQ requesters.
- Round-robin arbitration picks one requester; the block then sequences one operation at a time: issue, wait for the pack-stage p_valid, return a buffered response.
- Drives the datapath `enable` so the pipeline is flushed between operations.
- Enforces a timeout so a stuck datapath cannot hang the requesters.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- LAT_MAX, 16, max WAIT cycles before timeout (4..255).
- ID_W, $clog2(N_REQ) (min 1), width of requester index.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  16*N_REQ  FP16 operands; requester i in bits [16i+15:16i].
- req_ready  out  N_REQ  one-hot accept pulse.
- core_enable  out  1  datapath enable; low clears the datapath.
- core_start  out  1  one-cycle operand valid into the datapath.
- core_operand  out  16  FP16 operand to the datapath.
- core_p_valid  in  1  result valid from the pack stage.
- core_result  in  16  packed FP16 result.
- core_flags  in  3  {is_nan, is_pinf, is_ninf} from the pack stage.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  16  FP16 result.
- rsp_id  out  ID_W  index of the requester served.
- rsp_flags  out  3  {nan, pinf, ninf}.
- rsp_timeout  out  1  response was produced by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (asynchronous, any state):
- state=IDLE; every output 0.
- Round-robin pointer last=N_REQ-1, so requester 0 wins first.
- WAIT counter 0.

FSM states: IDLE, ISSUE, WAIT, HOLD.

IDLE:
- core_enable=0.
- If any req_valid: grant g = first index with req_valid set, searching from last+1 and wrapping modulo N_REQ.
- Grant cycle: req_ready[g]=1 (combinational, this cycle only); latch req_data[g] into the operand register and g into the id register; last<=g; go to ISSUE.
- Otherwise stay in IDLE with req_ready all zero.

ISSUE (exactly 1 cycle):
- core_enable=1, core_start=1, core_operand=latched operand.
- cnt<=0; go to WAIT.

WAIT:
- core_enable=1, core_start=0.
- If core_p_valid: register core_result into rsp_data and core_flags into rsp_flags; rsp_timeout<=0; go to HOLD.
- Else if cnt==LAT_MAX-1: rsp_data<=16'hFE00; rsp_flags<=3'b100; rsp_timeout<=1; go to HOLD.
- Else cnt<=cnt+1.
- core_p_valid has priority over timeout in the same cycle.

HOLD:
- core_enable=0, rsp_valid=1.
- rsp_data, rsp_id, rsp_flags and rsp_timeout are stable until the handshake.
- On rsp_valid&&rsp_ready: go to IDLE.
- No request is accepted during HOLD.

Rules common to all states:
- core_p_valid is ignored outside WAIT (late results are dropped).
- busy=1 in ISSUE, WAIT and HOLD.
- req_ready is never high outside IDLE and is at most one-hot.
- Best-case latency: grant at cycle T; core_start at T+1; a datapath of latency L raises p_valid at T+1+L; rsp_valid is high from T+2+L.
- Throughput: at most one operation in flight.
- The earliest next grant is the cycle after the response handshake.
- req_valid dropped before grant: the request is simply not selected; the grant is evaluated combinationally in the same cycle.
- Width rules: cnt is 8 bits; the grant search is modulo N_REQ with no out-of-range index.

Decomposition:
- Package sqrt_pkg holds:
  - FP16 constants QNAN=16'hFE00, PINF=16'h7C00, NINF=16'hFC00.
  - FLAG_NAN/PINF/NINF bit positions.
  - State enum {IDLE, ISSUE, WAIT, HOLD}.
- One sub-module, rr_arbiter: parameter N; inputs req[N], last; output grant one-hot plus index. Purely combinational.
- All sequencing stays in sqrt_sched.

Test Plan:
1. Single request: req 0 with 16'h4400, core model L=3 returns 16'h4000 with flags 0 → req_ready[0] at T; core_start at T+1; rsp_valid at T+5 with rsp_data=16'h4000, rsp_id=0, rsp_timeout=0.
2. Fairness: both requesters hold valid for 6 operations, rsp_ready=1 → grant order 0,1,0,1,0,1; req_ready never two-hot.
3. Timeout: core never asserts p_valid, LAT_MAX=16 → rsp_valid after 16 WAIT cycles with rsp_data=16'hFE00, rsp_flags=3'b100, rsp_timeout=1. A late p_valid during HOLD/IDLE is ignored.
4. Backpressure: rsp_ready=0 for 10 cycles with req 1 also valid → rsp fields stable, req_ready stays 0, busy=1. The grant to req 1 occurs only after the handshake.
5. Reset mid-WAIT: assert rst_n=0 → all outputs 0 immediately. After release, with both requesting, the first grant goes to req 0.
6. Boundary: p_valid arrives in the same cycle cnt==LAT_MAX-1 with 16'h7C00 and flags 3'b010 → normal response 16'h7C00, rsp_flags=3'b010, rsp_timeout=0.
